// File: rtl/thread_dispatch_scheduler.sv
// thread_dispatch_scheduler: priority + round-robin picker for a 16-thread pool with valid/ready dispatch
module thread_dispatch_scheduler #(
  parameter int NUM_THREADS = 16,
  parameter int TID_W = 4,
  parameter int PRIO_W = 2,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wake_valid,
  input  logic [TID_W-1:0]       wake_tid,
  input  logic                   cfg_we,
  input  logic [TID_W-1:0]       cfg_tid,
  input  logic [PRIO_W-1:0]      cfg_prio,
  output logic                   disp_valid,
  output logic [TID_W-1:0]       disp_tid,
  input  logic                   disp_ready,
  output logic [NUM_THREADS-1:0] ready_mask,
  output logic                   busy,
  output logic [CNT_W-1:0]       disp_count
);
  typedef enum logic {IDLE, OFFER} state_t;
  state_t state;
  logic [PRIO_W-1:0] prio [NUM_THREADS];
  logic [TID_W-1:0] last_tid;
  logic [TID_W-1:0] winner;
  logic [TID_W-1:0] idx;
  logic [PRIO_W-1:0] max_prio;
  logic hs;
  assign hs = disp_valid & disp_ready;
  assign busy = (|ready_mask) | disp_valid;
  // winner: highest priority among ready threads, first found scanning up from last_tid+1
  always_comb begin
    max_prio = '0;
    winner = '0;
    idx = '0;
    for (int i = 0; i < NUM_THREADS; i++)
      if (ready_mask[i] && prio[i] > max_prio) max_prio = prio[i];
    for (int k = NUM_THREADS; k >= 1; k--) begin
      idx = last_tid + TID_W'(k);
      if (ready_mask[idx] && prio[idx] == max_prio) winner = idx;
    end
  end
  // ready flags: acceptance clears the offered thread, a wake sets (and wins over the clear)
  always_ff @(posedge clk) begin
    if (rst) ready_mask <= '0;
    else ready_mask <= (ready_mask & ~(hs ? NUM_THREADS'(1) << disp_tid : '0))
                     | (wake_valid ? NUM_THREADS'(1) << wake_tid : '0);
  end
  // priority registers
  always_ff @(posedge clk) begin
    if (rst) for (int i = 0; i < NUM_THREADS; i++) prio[i] <= '0;
    else if (cfg_we) prio[cfg_tid] <= cfg_prio;
  end
  // offer FSM: latch a winner in IDLE, hold it stable in OFFER until accepted
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      disp_valid <= 1'b0;
      disp_tid <= '0;
      last_tid <= TID_W'(NUM_THREADS - 1);
      disp_count <= '0;
    end else if (state == IDLE) begin
      if (|ready_mask) begin
        disp_tid <= winner;
        disp_valid <= 1'b1;
        state <= OFFER;
      end
    end else if (disp_ready) begin
      last_tid <= disp_tid;
      disp_count <= disp_count + 1'b1;
      disp_valid <= 1'b0;
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_thread_dispatch_scheduler.sv
// tb_thread_dispatch_scheduler: directed + random stimulus against a behavioural scheduler model
module tb_thread_dispatch_scheduler;
  logic clk = 1'b0;
  logic rst, wake_valid, cfg_we, disp_ready, disp_valid, busy;
  logic [3:0] wake_tid, cfg_tid, disp_tid;
  logic [1:0] cfg_prio;
  logic [15:0] ready_mask, disp_count;
  int checks = 0, errors = 0;
  bit [15:0] m_ready;
  int m_prio [16];
  int m_last, m_tid, m_count;
  bit m_valid;
  int acc_q [$];

  always #5 clk = ~clk;

  thread_dispatch_scheduler dut (
    .clk(clk), .rst(rst), .wake_valid(wake_valid), .wake_tid(wake_tid),
    .cfg_we(cfg_we), .cfg_tid(cfg_tid), .cfg_prio(cfg_prio),
    .disp_valid(disp_valid), .disp_tid(disp_tid), .disp_ready(disp_ready),
    .ready_mask(ready_mask), .busy(busy), .disp_count(disp_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // highest priority level present wins; within it, first ready thread after the last dispatched one
  function automatic int pick();
    for (int p = 3; p >= 0; p--)
      for (int k = 1; k <= 16; k++) begin
        int t = (m_last + k) % 16;
        if (m_ready[t] && m_prio[t] == p) return t;
      end
    return 0;
  endfunction

  task automatic step(input bit r, input bit wv, input int wt, input bit cw, input int ct, input int cp, input bit dr);
    int nt;
    bit hs;
    rst = r; wake_valid = wv; wake_tid = 4'(wt);
    cfg_we = cw; cfg_tid = 4'(ct); cfg_prio = 2'(cp); disp_ready = dr;
    if (r) begin
      m_ready = '0; m_last = 15; m_tid = 0; m_count = 0; m_valid = 0;
      for (int i = 0; i < 16; i++) m_prio[i] = 0;
    end else begin
      if (disp_valid && dr) acc_q.push_back(int'(disp_tid));
      hs = m_valid && dr;
      nt = pick();
      if (hs) begin
        m_ready[m_tid] = 1'b0; m_last = m_tid; m_count = (m_count + 1) % 65536; m_valid = 0;
      end else if (!m_valid && m_ready != 0) begin
        m_valid = 1; m_tid = nt;
      end
      if (wv) m_ready[wt] = 1'b1;
      if (cw) m_prio[ct] = cp;
    end
    @(posedge clk);
    #1;
    chk("disp_valid", 32'(disp_valid), 32'(m_valid));
    chk("disp_tid", 32'(disp_tid), 32'(m_tid));
    chk("ready_mask", 32'(ready_mask), 32'(m_ready));
    chk("busy", 32'(busy), 32'(m_ready != 0 || m_valid));
    chk("disp_count", 32'(disp_count), 32'(m_count));
  endtask

  task automatic idle(input int n, input bit dr);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, dr);
  endtask

  task automatic wake(input int t, input bit dr);
    step(0, 1, t, 0, 0, 0, dr);
  endtask

  task automatic chk_order(input string tag, input int exp [$]);
    chk({tag, "_len"}, 32'(acc_q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < acc_q.size(); i++) chk(tag, 32'(acc_q[i]), 32'(exp[i]));
    acc_q.delete();
  endtask

  initial begin
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(10, 0);
    chk("idle_valid", 32'(disp_valid), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_count", 32'(disp_count), 0);
    wake(5, 1);
    idle(1, 1);
    chk("single_valid", 32'(disp_valid), 1);
    chk("single_tid", 32'(disp_tid), 5);
    idle(1, 1);
    chk("single_mask", 32'(ready_mask), 0);
    chk("single_count", 32'(disp_count), 1);
    acc_q.delete();
    wake(3, 0); wake(9, 0); wake(14, 0);
    idle(8, 1);
    chk_order("rr_order", '{3, 9, 14});
    wake(3, 0); wake(14, 0);
    idle(6, 1);
    chk_order("rr_wrap", '{3, 14});
    step(0, 0, 0, 1, 2, 1, 0);
    step(0, 0, 0, 1, 7, 3, 0);
    wake(0, 0); wake(2, 0); wake(7, 0);
    idle(1, 1);
    idle(2, 0);
    chk("prio_tid", 32'(disp_tid), 7);
    wake(12, 0);
    step(0, 0, 0, 1, 7, 0, 0);
    idle(1, 0);
    chk("prio_hold", 32'(disp_tid), 7);
    idle(8, 1);
    chk_order("prio_order", '{0, 7, 2, 12});
    wake(4, 0);
    idle(1, 0);
    chk("same_tid", 32'(disp_tid), 4);
    wake(4, 1);
    chk("same_requeue", 32'(ready_mask[4]), 1);
    idle(1, 0);
    chk("same_reoffer", 32'(disp_tid), 4);
    idle(1, 1);
    wake(6, 0);
    idle(1, 0);
    chk("rst_pre_tid", 32'(disp_tid), 6);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("rst_valid", 32'(disp_valid), 0);
    chk("rst_mask", 32'(ready_mask), 0);
    wake(6, 0);
    idle(1, 0);
    chk("rst_reoffer", 32'(disp_tid), 6);
    idle(1, 1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(199) == 0, $urandom_range(1), int'($urandom_range(15)),
           $urandom_range(9) == 0, int'($urandom_range(15)), int'($urandom_range(3)), $urandom_range(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
